// File: rtl/decl_stream_arbiter.sv
// decl_stream_arbiter
// Shares one intcheck declaration checker between two byte sources. Each source fills a
// private FIFO. Complete statements (terminated by ';') are granted round-robin and replayed
// to the checker back-to-back. The tagged pass/fail result is then reported.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   s0_*/s1_*             source byte streams (data/valid in, ready out)
//   chk_in, chk_rst       byte and active-high reset driven to the checker
//   chk_out               checker verdict, valid the cycle after ';' is clocked in
//   res_valid/src/ok      one-cycle tagged result strobe
//   ovf_err               sticky per-source overflow flags
//   ok_cnt0, ok_cnt1      per-source legal-declaration counters (wrap at 256)
module decl_stream_arbiter #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] chk_in,
  output logic       chk_rst,
  input  logic       chk_out,
  output logic       res_valid,
  output logic       res_src,
  output logic       res_ok,
  output logic [1:0] ovf_err,
  output logic [7:0] ok_cnt0,
  output logic [7:0] ok_cnt1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [7:0] Semi = 8'h3B;

  typedef enum logic [1:0] {StIdle, StStream, StCapture} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_q, last_d;

  logic [1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0][PW-1:0] stmt_cnt_q, stmt_cnt_d;
  logic [1:0]         ovf_q, ovf_d;
  logic [1:0][7:0]    ok_cnt_q, ok_cnt_d;

  logic [7:0] mem_q [2][DEPTH];

  logic [1:0][7:0]    in_data;
  logic [1:0]         in_valid;
  logic [1:0][PW-1:0] occ;
  logic [1:0]         full, push, pop, flush, cand;
  logic [7:0]         head;

  assign in_data[0]  = s0_data;
  assign in_data[1]  = s1_data;
  assign in_valid[0] = s0_valid;
  assign in_valid[1] = s1_valid;

  // Head of the granted FIFO; only meaningful in StStream.
  assign head = mem_q[gnt_q][rd_ptr_q[gnt_q][AW-1:0]];

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    stmt_cnt_d = stmt_cnt_q;
    ovf_d      = ovf_q;
    occ        = '0;
    full       = '0;
    push       = '0;
    pop        = '0;
    flush      = '0;
    cand       = '0;
    for (int i = 0; i < 2; i++) begin
      occ[i]   = wr_ptr_q[i] - rd_ptr_q[i];
      full[i]  = (occ[i] == PW'(DEPTH));
      // ready is !full of registered pointers, so valid never reaches ready combinationally
      push[i]  = in_valid[i] && !full[i];
      pop[i]   = (state_q == StStream) && (gnt_q == 1'(i));
      // A full FIFO with no terminator can never drain: drop its contents
      flush[i] = full[i] && (stmt_cnt_q[i] == '0);
      cand[i]  = (stmt_cnt_q[i] != '0);

      wr_ptr_d[i]   = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i]   = rd_ptr_q[i] + PW'(pop[i]);
      stmt_cnt_d[i] = stmt_cnt_q[i]
                    + PW'(push[i] && (in_data[i] == Semi))
                    - PW'(pop[i] && (head == Semi));
      if (flush[i]) begin
        // push is impossible here (full), stmt_cnt is already zero
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        ovf_d[i]    = 1'b1;
      end
    end
  end

  // Arbitration FSM next state
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    ok_cnt_d = ok_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cand != 2'b00) begin
          // Non-last source wins when it has a statement, else the last one does
          gnt_d   = cand[~last_q] ? ~last_q : last_q;
          last_d  = gnt_d;
          state_d = StStream;
        end
      end
      StStream: begin
        if (head == Semi) state_d = StCapture;
      end
      StCapture: begin
        if (chk_out) ok_cnt_d[gnt_q] = ok_cnt_q[gnt_q] + 8'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stmt_cnt_q <= '0;
      ovf_q      <= '0;
      ok_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stmt_cnt_q <= stmt_cnt_d;
      ovf_q      <= ovf_d;
      ok_cnt_q   <= ok_cnt_d;
    end
  end

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_data[i];
    end
  end

  // Outputs decoded from registered state only
  assign s0_ready  = !full[0];
  assign s1_ready  = !full[1];
  assign chk_rst   = (state_q == StIdle);
  assign chk_in    = (state_q == StStream) ? head : 8'h00;
  assign res_valid = (state_q == StCapture);
  assign res_src   = gnt_q;
  assign res_ok    = (state_q == StCapture) && chk_out;
  assign ovf_err   = ovf_q;
  assign ok_cnt0   = ok_cnt_q[0];
  assign ok_cnt1   = ok_cnt_q[1];

endmodule

// File: tb/tb_decl_stream_arbiter.sv
// Directed testbench for decl_stream_arbiter with a behavioural intcheck model.
module tb_decl_stream_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s0_data = 8'h00;
  logic       s0_valid = 1'b0;
  logic       s0_ready;
  logic [7:0] s1_data = 8'h00;
  logic       s1_valid = 1'b0;
  logic       s1_ready;
  logic [7:0] chk_in;
  logic       chk_rst;
  logic       chk_out;
  logic       res_valid;
  logic       res_src;
  logic       res_ok;
  logic [1:0] ovf_err;
  logic [7:0] ok_cnt0;
  logic [7:0] ok_cnt1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_push_cyc [2];

  typedef struct {
    logic src;
    logic ok;
    int   cyc;
  } res_t;

  res_t       res_q[$];
  logic [7:0] byte_q[$];
  int         byte_cyc[$];

  decl_stream_arbiter #(.DEPTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s0_data   (s0_data),
    .s0_valid  (s0_valid),
    .s0_ready  (s0_ready),
    .s1_data   (s1_data),
    .s1_valid  (s1_valid),
    .s1_ready  (s1_ready),
    .chk_in    (chk_in),
    .chk_rst   (chk_rst),
    .chk_out   (chk_out),
    .res_valid (res_valid),
    .res_src   (res_src),
    .res_ok    (res_ok),
    .ovf_err   (ovf_err),
    .ok_cnt0   (ok_cnt0),
    .ok_cnt1   (ok_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // intcheck model: accepts "int" <spaces> identifier ";"
  logic [2:0] ck_st = 3'd0;
  assign chk_out = (ck_st == 3'd6);
  always @(posedge clk) begin
    if (chk_rst !== 1'b0) ck_st <= 3'd0;
    else begin
      case (ck_st)
        3'd0: ck_st <= (chk_in == 8'h69) ? 3'd1 : 3'd7;
        3'd1: ck_st <= (chk_in == 8'h6E) ? 3'd2 : 3'd7;
        3'd2: ck_st <= (chk_in == 8'h74) ? 3'd3 : 3'd7;
        3'd3: ck_st <= (chk_in == 8'h20) ? 3'd4 : 3'd7;
        3'd4: begin
          if (chk_in == 8'h20) ck_st <= 3'd4;
          else if ((chk_in >= 8'h61 && chk_in <= 8'h7A) || chk_in == 8'h5F) ck_st <= 3'd5;
          else ck_st <= 3'd7;
        end
        3'd5: begin
          if ((chk_in >= 8'h61 && chk_in <= 8'h7A) || chk_in == 8'h5F ||
              (chk_in >= 8'h30 && chk_in <= 8'h39)) ck_st <= 3'd5;
          else if (chk_in == 8'h3B) ck_st <= 3'd6;
          else ck_st <= 3'd7;
        end
        default: ck_st <= 3'd7;
      endcase
    end
  end

  // Log streamed bytes and results on the falling edge
  always @(negedge clk) begin
    if (chk_rst === 1'b0 && res_valid === 1'b0) begin
      byte_q.push_back(chk_in);
      byte_cyc.push_back(cyc);
    end
    if (res_valid === 1'b1) res_q.push_back('{src: res_src, ok: res_ok, cyc: cyc});
  end

  task automatic clear_logs();
    res_q.delete();
    byte_q.delete();
    byte_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic push_byte(input int src, input logic [7:0] b);
    int guard;
    guard = 0;
    while (((src == 0) ? s0_ready : s1_ready) !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout src%0d: ready stayed low, required 1", src);
    end
    if (src == 0) begin
      s0_data  = b;
      s0_valid = 1'b1;
    end else begin
      s1_data  = b;
      s1_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if (src == 0) s0_valid = 1'b0;
    else s1_valid = 1'b0;
    last_push_cyc[src] = cyc;
  endtask

  task automatic send(input int src, input string s);
    for (int i = 0; i < s.len(); i++) push_byte(src, s[i]);
  endtask

  task automatic wait_res(input int n, input int limit, output bit got);
    int k;
    k = 0;
    while (res_q.size() < n && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    got = (res_q.size() >= n);
  endtask

  task automatic check_bytes(input string name, input int base, input string exp);
    checks++;
    if (byte_q.size() < base + exp.len()) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes, required %0d", name, byte_q.size(),
               base + exp.len());
    end else begin
      for (int i = 0; i < exp.len(); i++) begin
        checks++;
        if (byte_q[base+i] !== exp[i]) begin
          errors++;
          $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, byte_q[base+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (chk_rst !== 1'b1) begin errors++;
      $display("FAIL rst_chk_rst: got %b, required 1", chk_rst); end
    checks++; if (chk_in !== 8'h00) begin errors++;
      $display("FAIL rst_chk_in: got %02h, required 00", chk_in); end
    checks++; if (res_valid !== 1'b0 || res_src !== 1'b0 || res_ok !== 1'b0) begin errors++;
      $display("FAIL rst_res: got %b%b%b, required 000", res_valid, res_src, res_ok); end
    checks++; if (ovf_err !== 2'b00) begin errors++;
      $display("FAIL rst_ovf: got %b, required 00", ovf_err); end
    checks++; if (ok_cnt0 !== 8'd0 || ok_cnt1 !== 8'd0) begin errors++;
      $display("FAIL rst_cnt: got %0d/%0d, required 0/0", ok_cnt0, ok_cnt1); end
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin errors++;
      $display("FAIL rst_ready: got %b%b, required 11", s0_ready, s1_ready); end
  endtask

  task automatic test_single();
    bit got;
    int semi;
    do_reset();
    send(0, "int a;");
    semi = last_push_cyc[0];
    wait_res(1, 50, got);
    checks++; if (!got) begin errors++;
      $display("FAIL single_timeout: got %0d results, required 1", res_q.size()); end
    check_bytes("single", 0, "int a;");
    if (got) begin
      checks++; if (byte_cyc[0] !== semi + 1 || byte_cyc[5] !== semi + 6) begin errors++;
        $display("FAIL single_stream_cyc: got %0d..%0d, required %0d..%0d",
                 byte_cyc[0], byte_cyc[5], semi + 1, semi + 6); end
      checks++; if (res_q[0].cyc !== semi + 7) begin errors++;
        $display("FAIL single_res_cyc: got %0d, required %0d", res_q[0].cyc, semi + 7); end
      checks++; if (res_q[0].src !== 1'b0 || res_q[0].ok !== 1'b1) begin errors++;
        $display("FAIL single_res: got src=%b ok=%b, required src=0 ok=1",
                 res_q[0].src, res_q[0].ok); end
    end
    @(posedge clk); #1;
    checks++; if (ok_cnt0 !== 8'd1) begin errors++;
      $display("FAIL single_ok_cnt0: got %0d, required 1", ok_cnt0); end
  endtask

  task automatic test_round_robin();
    bit got;
    logic exp_src [4];
    logic exp_ok [4];
    int   starts [4];
    exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_ok  = '{1'b1, 1'b1, 1'b0, 1'b0};
    starts  = '{0, 6, 13, 17};
    do_reset();
    fork
      begin send(0, "int a;"); send(0, "int;"); end
      begin send(1, "int bc;"); send(1, "inta;"); end
    join
    wait_res(4, 200, got);
    checks++; if (!got) begin errors++;
      $display("FAIL rr_timeout: got %0d results, required 4", res_q.size()); end
    check_bytes("rr", 0, "int a;int bc;int;inta;");
    if (got && byte_q.size() >= 22) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (res_q[k].src !== exp_src[k] || res_q[k].ok !== exp_ok[k]) begin errors++;
          $display("FAIL rr_res%0d: got src=%b ok=%b, required src=%b ok=%b", k,
                   res_q[k].src, res_q[k].ok, exp_src[k], exp_ok[k]); end
      end
      for (int k = 0; k < 3; k++) begin
        checks++; if (byte_cyc[starts[k+1]] !== res_q[k].cyc + 2) begin errors++;
          $display("FAIL rr_gap%0d: got start %0d, required %0d", k, byte_cyc[starts[k+1]],
                   res_q[k].cyc + 2); end
      end
    end
    @(posedge clk); #1;
    checks++; if (ok_cnt0 !== 8'd1 || ok_cnt1 !== 8'd1) begin errors++;
      $display("FAIL rr_cnt: got %0d/%0d, required 1/1", ok_cnt0, ok_cnt1); end
  endtask

  task automatic test_partial();
    bit got;
    do_reset();
    fork
      send(1, "int b");
      send(0, "int;");
    join
    wait_res(1, 50, got);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (res_q.size() !== 1 || byte_q.size() !== 4) begin errors++;
      $display("FAIL partial_only_src0: got %0d results %0d bytes, required 1 and 4",
               res_q.size(), byte_q.size()); end
    if (res_q.size() >= 1) begin
      checks++; if (res_q[0].src !== 1'b0 || res_q[0].ok !== 1'b0) begin errors++;
        $display("FAIL partial_res0: got src=%b ok=%b, required src=0 ok=0",
                 res_q[0].src, res_q[0].ok); end
    end
    send(1, ";");
    wait_res(2, 50, got);
    checks++; if (!got) begin errors++;
      $display("FAIL partial_timeout: got %0d results, required 2", res_q.size()); end
    check_bytes("partial", 0, "int;int b;");
    if (got) begin
      checks++; if (res_q[1].src !== 1'b1 || res_q[1].ok !== 1'b1) begin errors++;
        $display("FAIL partial_res1: got src=%b ok=%b, required src=1 ok=1",
                 res_q[1].src, res_q[1].ok); end
    end
    @(posedge clk); #1;
    checks++; if (ok_cnt0 !== 8'd0 || ok_cnt1 !== 8'd1) begin errors++;
      $display("FAIL partial_cnt: got %0d/%0d, required 0/1", ok_cnt0, ok_cnt1); end
  endtask

  task automatic test_overflow();
    bit got;
    do_reset();
    send(0, "abcdefghijklmnop");
    checks++; if (s0_ready !== 1'b0 || ovf_err !== 2'b00) begin errors++;
      $display("FAIL ovf_full: got ready=%b ovf=%b, required ready=0 ovf=00", s0_ready, ovf_err);
    end
    @(posedge clk); #1;
    checks++; if (s0_ready !== 1'b1 || ovf_err !== 2'b01) begin errors++;
      $display("FAIL ovf_flush: got ready=%b ovf=%b, required ready=1 ovf=01", s0_ready, ovf_err);
    end
    send(0, "int c;");
    wait_res(1, 50, got);
    checks++; if (!got) begin errors++;
      $display("FAIL ovf_timeout: got %0d results, required 1", res_q.size()); end
    check_bytes("ovf", 0, "int c;");
    checks++; if (byte_q.size() !== 6) begin errors++;
      $display("FAIL ovf_extra_bytes: got %0d bytes, required 6", byte_q.size()); end
    if (got) begin
      checks++; if (res_q[0].src !== 1'b0 || res_q[0].ok !== 1'b1) begin errors++;
        $display("FAIL ovf_res: got src=%b ok=%b, required src=0 ok=1",
                 res_q[0].src, res_q[0].ok); end
    end
    @(posedge clk); #1;
    checks++; if (ok_cnt0 !== 8'd1 || ovf_err !== 2'b01) begin errors++;
      $display("FAIL ovf_after: got cnt=%0d ovf=%b, required cnt=1 ovf=01", ok_cnt0, ovf_err);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    do_reset();
    send(1, "int zz;");
    k = 0;
    while (byte_q.size() < 2 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++; if (byte_q.size() < 2) begin errors++;
      $display("FAIL midrst_stream: got %0d bytes, required 2", byte_q.size()); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (chk_rst !== 1'b1 || chk_in !== 8'h00) begin errors++;
      $display("FAIL midrst_chk: got rst=%b in=%02h, required rst=1 in=00", chk_rst, chk_in); end
    checks++; if (res_valid !== 1'b0 || res_src !== 1'b0 || res_ok !== 1'b0) begin errors++;
      $display("FAIL midrst_res: got %b%b%b, required 000", res_valid, res_src, res_ok); end
    checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1 || ovf_err !== 2'b00) begin errors++;
      $display("FAIL midrst_misc: got ready=%b%b ovf=%b, required 11/00",
               s0_ready, s1_ready, ovf_err); end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (res_q.size() !== 0) begin errors++;
      $display("FAIL midrst_no_result: got %0d results, required 0", res_q.size()); end
    checks++; if (ok_cnt0 !== 8'd0 || ok_cnt1 !== 8'd0) begin errors++;
      $display("FAIL midrst_cnt: got %0d/%0d, required 0/0", ok_cnt0, ok_cnt1); end
  endtask

  task automatic test_back_to_back();
    bit got;
    do_reset();
    send(0, "int a;int bb;");
    wait_res(2, 80, got);
    checks++; if (!got) begin errors++;
      $display("FAIL b2b_timeout: got %0d results, required 2", res_q.size()); end
    check_bytes("b2b", 0, "int a;int bb;");
    if (got) begin
      checks++; if (res_q[0].ok !== 1'b1 || res_q[1].ok !== 1'b1 ||
                    res_q[0].src !== 1'b0 || res_q[1].src !== 1'b0) begin errors++;
        $display("FAIL b2b_res: got ok=%b%b src=%b%b, required ok=11 src=00",
                 res_q[0].ok, res_q[1].ok, res_q[0].src, res_q[1].src); end
    end
    @(posedge clk); #1;
    checks++; if (ok_cnt0 !== 8'd2) begin errors++;
      $display("FAIL b2b_cnt: got %0d, required 2", ok_cnt0); end
  endtask

  task automatic test_wrap();
    bit got;
    int bad;
    do_reset();
    for (int n = 0; n < 255; n++) send(0, "int a;");
    wait_res(255, 200, got);
    @(posedge clk); #1;
    checks++; if (ok_cnt0 !== 8'd255) begin errors++;
      $display("FAIL wrap_255: got %0d, required 255", ok_cnt0); end
    send(0, "int a;");
    wait_res(256, 100, got);
    @(posedge clk); #1;
    checks++; if (!got || ok_cnt0 !== 8'd0) begin errors++;
      $display("FAIL wrap_0: got %0d (results %0d), required 0 (256)", ok_cnt0, res_q.size());
    end
    bad = 0;
    foreach (res_q[k]) if (res_q[k].ok !== 1'b1 || res_q[k].src !== 1'b0) bad++;
    checks++; if (bad !== 0 || ovf_err !== 2'b00) begin errors++;
      $display("FAIL wrap_results: got %0d bad, ovf=%b, required 0 bad, ovf=00", bad, ovf_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_partial();
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decl_stream_arbiter.md
# decl_stream_arbiter

Shares one `intcheck` declaration checker between two independent character sources. Each source writes bytes into a private statement FIFO. The arbiter grants the checker to one source per complete statement (terminated by `;`), round-robin, and replays that statement to the checker back-to-back with no bubbles. It then returns a tagged pass/fail result. The block sits between the lexer-side byte producers and the single `intcheck` instance, and owns that instance's reset.

## Interface
- `DEPTH`, 16: per-source FIFO depth in bytes; power of two, ≥4.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `s0_data`, `s1_data`  in  8  source byte (ASCII).
- `s0_valid`, `s1_valid`  in  1  source byte offered.
- `s0_ready`, `s1_ready`  out  1  FIFO can accept; equals registered not-full.
- `chk_in`  out  8  byte to checker `in`.
- `chk_rst`  out  1  active-high reset to the checker.
- `chk_out`  in  1  checker `out`, a Moore output valid the cycle after the terminating `;` is clocked in.
- `res_valid`  out  1  one-cycle strobe: a result is available.
- `res_src`  out  1  source index of the result.
- `res_ok`  out  1  1 means the statement was a legal declaration.
- `ovf_err`  out  2  sticky per-source overflow flag.
- `ok_cnt0`, `ok_cnt1`  out  8  count of legal declarations per source; wraps modulo 256.

## Operation
- Push to FIFO i on `si_valid && si_ready`. If the pushed byte is `;` (8'h3B), `stmt_cnt[i]` increments. The counter is ≤ DEPTH.
- FSM states: IDLE, STREAM, CAPTURE.
- **IDLE**
  - `chk_rst`=1, `chk_in`=8'h00.
  - Candidates are sources with `stmt_cnt>0`.
  - Pick by round-robin from a `last` pointer: the non-last source wins if it is a candidate, otherwise the last source. `last` resets to 1, so source 0 has first priority.
  - With a winner: latch `gnt`, update `last`, go to STREAM.
- **STREAM**
  - `chk_rst`=0, `chk_in`=FIFO[`gnt`] head, and the head is popped every cycle.
  - When the popped byte is `;`: decrement `stmt_cnt[gnt]` and go to CAPTURE.
  - The FIFO cannot run empty in STREAM, because a counted `;` is guaranteed to be present.
- **CAPTURE**
  - `chk_rst`=0, `chk_in`=8'h00.
  - `res_valid`=1, `res_src`=`gnt`, `res_ok`=`chk_out`.
  - If `chk_out` is set, increment `ok_cnt[gnt]`.
  - Go to IDLE.
- **Overflow**
  - Trigger: FIFO i is full and `stmt_cnt[i]`==0.
  - The next cycle flushes FIFO i (pointers cleared) and sets `ovf_err[i]`, which stays set until reset.
  - FIFO i cannot be in STREAM under this condition, since its `stmt_cnt` is 0.
- **Simultaneous events**
  - Push and pop on the same FIFO in the same cycle: both occur and the occupancy count is unchanged.
  - A `;` push and a `;` pop on the same FIFO in the same cycle: `stmt_cnt` is unchanged.
  - Flush and push in the same cycle cannot occur, because `ready`=0 when full.
- Bytes other than `;` are forwarded verbatim. Whitespace and syntax are judged only by the checker.

## Timing
- **Reset** (`reset_n`=0 at an edge) sets:
  - FSM=IDLE, FIFOs empty, `stmt_cnt`=0, `last`=1, `gnt`=0.
  - `chk_rst`=1, `chk_in`=0, `res_valid`=0, `res_src`=0, `res_ok`=0, `ovf_err`=0, counters=0, `s*_ready`=1 the cycle after.
- **Reset mid-STREAM** abandons the statement and emits no result.
- **Latency**
  - The byte containing `;` is pushed at edge T, so `stmt_cnt` is visible at T+1.
  - IDLE grants at T+1 and STREAM starts at T+2.
  - For a statement of L bytes: STREAM lasts L cycles, CAPTURE follows, and `res_valid` is high in cycle T+2+L.
- **Throughput**: one statement per L+2 cycles (L STREAM, 1 CAPTURE, 1 IDLE). IDLE always holds `chk_rst`=1 for at least one cycle between statements.
- **Outputs**: all outputs are registered or decoded from the registered state only. There is no combinational path from `s*_valid` to `s*_ready`.

## Test plan
- **Single declaration**
  - Stimulus: source 0 sends "int a;" (6 bytes) with the checker modelled.
  - Required: 6 contiguous `chk_in` bytes 69 6E 74 20 61 3B, `chk_rst` low during them, then `res_valid`=1, `res_src`=0, `res_ok`=1, `ok_cnt0`=1.
- **Round-robin**
  - Stimulus: both sources hold 2 complete statements at once.
  - Required: grant order 0,1,0,1. Each result is tagged correctly. The next statement starts 2 cycles after each CAPTURE.
- **Partial statement not granted**
  - Stimulus: source 1 sends "int b" with no `;`, while source 0 sends "int;".
  - Required: only source 0 streams, giving `res_ok`=0. Source 1 streams only after its `;` arrives.
- **Overflow**
  - Stimulus: source 0 pushes 16 bytes with no `;`.
  - Required: `s0_ready`=0 for one cycle, then the FIFO is flushed, `ovf_err`=2'b01, and `s0_ready`=1. A later "int c;" still passes.
- **Mid-stream reset**
  - Stimulus: `reset_n`=0 during STREAM of source 1.
  - Required: no `res_valid`; all outputs at reset values the next cycle; `ok_cnt`=0.
- **Concurrent push/pop and counter wrap**
  - Stimulus: source 0 pushes a new statement while its current one streams. Separately, 256 legal declarations are sent.
  - Required: no lost bytes during the concurrent push/pop. `ok_cnt0` wraps 255→0.
